// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [2:0] OFF_TXDATA = 3'h0;
  localparam logic [2:0] OFF_STATUS = 3'h4;

  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_CNT_LSB   = 4;

  localparam int unsigned FRAME_BITS = 10;

  // STATUS has a 4-bit occupancy field; deeper FIFOs report 15.
  function automatic logic [3:0] sat_count4(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus slice seen by the UART register window.
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [31:0] read_data;
  logic        sel;
  logic        clk_stall;

  modport master (
    output addr, write_data, memwrite, memread,
    input  read_data, sel, clk_stall
  );

  modport slave (
    input  addr, write_data, memwrite, memread,
    output read_data, sel, clk_stall
  );
endinterface

// File: rtl/uart_tx_mmio_byte_fifo.sv
// Byte-wide circular FIFO with occupancy count; DEPTH must be a power of two.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter behind a two-word MMIO window (TXDATA, STATUS),
// stalling the CPU clock on stores to a full FIFO.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_TC = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic          hit, is_status, tx_store;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          tc;
  logic          unused_bus_bits;

  assign unused_bus_bits = ^{bus.addr[1:0], bus.write_data[31:8], bus.memread};

  assign hit       = (bus.addr[31:3] == BASE_ADDR[31:3]);
  assign is_status = (bus.addr[2] == OFF_STATUS[2]);
  assign tx_store  = bus.memwrite & hit & (bus.addr[2] == OFF_TXDATA[2]);
  assign fifo_push = tx_store & ~fifo_full;

  assign bus.sel       = hit;
  assign bus.clk_stall = tx_store & fifo_full;

  always_comb begin
    status                        = '0;
    status[ST_FULL_BIT]           = fifo_full;
    status[ST_EMPTY_BIT]          = fifo_empty;
    status[ST_BUSY_BIT]           = (state_q != IDLE);
    status[ST_CNT_LSB +: 4]       = sat_count4(32'(fifo_count));
  end

  assign bus.read_data = (hit && is_status) ? status : '0;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.write_data[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tc = (baud_q == BAUD_TC);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (tc) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (tc) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is derived from the next state so the registered pin lines up with
  // the state it represents rather than lagging it by a cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the processor's data-memory bus, decoded in parallel with data_mem. It consumes CPU stores to a TX-data register, buffers bytes in a small FIFO, and serialises them as 8N1 on a single pin. It raises clk_stall on a store to a full FIFO; the top level ORs this into the existing stall that gates clk_proc.

Parameters:
BASE_ADDR, 32'h0000_2000, word-aligned base of the 2-word register window
CLKS_PER_BIT, 208, clk cycles per bit; 208 gives 115200 baud at 24 MHz; must be >= 2
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock; the ungated clk, not clk_proc
reset  in  1  asynchronous, active-high reset
addr  in  32  data-bus address from cpu
write_data  in  32  store data from cpu
memwrite  in  1  store strobe
memread  in  1  load strobe
read_data  out  32  load data; valid only when sel=1
sel  out  1  address hit for this block; top uses it to mux read_data
clk_stall  out  1  hold request toward clk_proc gating
tx  out  1  serial output, idle high

Behaviour:
- Decode compares addr[31:3] with BASE_ADDR[31:3]. addr[1:0] is ignored. sel = decode hit (combinational).
- Offset 0x0 is TXDATA (write-only). A store pushes write_data[7:0]; bits [31:8] are ignored. A load returns 0.
- Offset 0x4 is STATUS (read-only). A load returns {24'b0, count[3:0], 1'b0, busy, empty, full} in bits [31:0], i.e. bit0=full, bit1=empty, bit2=busy (FSM not IDLE), bits[7:4]=FIFO occupancy, all other bits 0. count saturates its encoding at FIFO_DEPTH<=15. Stores to STATUS are ignored.
- read_data is combinational from addr and state, so loads have zero added latency and never stall.
- Push occurs on the posedge when memwrite & sel & offset==0 & !full.
- clk_stall = memwrite & sel & offset==0 & full, combinational. Because the CPU holds its outputs while stalled, the store completes on the first edge after a slot frees.
- FIFO:
  - Push and pop in the same edge leave count unchanged; this is legal only when 0<count<DEPTH.
  - A push to an empty FIFO while the FSM is in IDLE is not bypassed.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. baud_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
  - IDLE: tx=1. If FIFO is non-empty, pop into shift_reg, clear baud_cnt, go to START.
  - START: tx=0. When baud_cnt hits terminal count, go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[0] (LSB first). At terminal count, shift right. At bit_idx=7, go to STOP; otherwise increment bit_idx.
  - STOP: tx=1. At terminal count, pop and go to START if FIFO is non-empty, with no idle gap; otherwise go to IDLE.
- Timing: a store accepted at edge N drives tx low after edge N+1 if the FSM was IDLE. A frame is exactly 10*CLKS_PER_BIT cycles.
- tx is registered, so it is glitch-free.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE, tx=1, FIFO emptied, baud_cnt=0, bit_idx=0, shift_reg=0.
  - The partial frame is abandoned.
  - Combinational outputs follow the reset state: clk_stall=0 whenever not full; STATUS reads 0x02.

Decomposition:
- uart_pkg holds:
  - state enum (IDLE/START/DATA/STOP)
  - register offsets (TXDATA=0x0, STATUS=0x4)
  - STATUS bit positions
  - frame length constant 10
- One sub-module, byte_fifo: parameterised DEPTH; ports clk, reset, push, din[7:0], pop, dout[7:0], full, empty, count.
- The FSM and bus decode live in uart_tx_mmio.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset, then idle. Required: tx=1, a STATUS load returns 0x0000_0002, clk_stall=0, sel=0 for addr=0x0.
- Store 0xFFFF_FFA5 to BASE. Required: tx goes low one cycle after the accepting edge and then emits bits 1,0,1,0,0,1,0,1 LSB-first, each held 4 cycles, followed by a 4-cycle stop bit high; total 40 cycles; STATUS afterwards = 0x02.
- Store 0x55 then 0x0F back-to-back. Required: the second start bit begins on the cycle immediately after the first stop bit ends; 80 cycles total with no extra idle.
- Store 6 bytes consecutively. Required:
  - The first 5 stores are accepted: 1 popped into the FSM, 4 buffered.
  - On the 6th store, clk_stall=1 until the FSM pops at the start of the next frame; the store is accepted on that edge.
  - While stalled, a STATUS read shows full=1 and count=4.
- Assert reset mid-DATA of a frame, with 2 bytes queued. Required: tx=1 immediately (asynchronously), STATUS=0x02 after release, and no further output.
- Load from BASE+4 while transmitting with 1 byte queued. Required: read_data=0x0000_0014 (count=1, busy=1) in the same cycle, with no stall.
